// File: rtl/pong_pkg.sv
// Shared types and constants for the LED pong match controller.
package pong_pkg;

    localparam int unsigned LED_W    = 8;
    localparam int unsigned SCORE_W  = 4;
    localparam int unsigned PERIOD_W = 24;
    localparam int unsigned SHOW_W   = 28;

    localparam logic [LED_W-1:0] LED_LEFT_END  = 8'h80;
    localparam logic [LED_W-1:0] LED_RIGHT_END = 8'h01;
    localparam logic [LED_W-1:0] LED_EMPTY     = 8'h00;

    typedef logic [SCORE_W-1:0] score_t;

    typedef enum logic [2:0] {
        SERVE_L,
        SERVE_R,
        RALLY,
        POINT,
        GAME_OVER
    } state_t;

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Buttons/shifter/display bundle; master is the match controller side.
interface pong_match_ctrl_if;
    import pong_pkg::*;

    logic             hit_l;
    logic             hit_r;
    logic [LED_W-1:0] led;
    logic             load_l;
    logic             load_r;
    logic             step;
    logic             dir;
    score_t           score_l;
    score_t           score_r;
    logic             show_score;
    logic             game_over;
    logic             winner;

    modport master (
        input  hit_l, hit_r, led,
        output load_l, load_r, step, dir, score_l, score_r,
               show_score, game_over, winner
    );

    modport slave (
        output hit_l, hit_r, led,
        input  load_l, load_r, step, dir, score_l, score_r,
               show_score, game_over, winner
    );

endinterface

// File: rtl/pong_tick_gen.sv
// Ball step timer: counts 0..period-1 while enabled; step is high while the count sits at period-1.
module pong_tick_gen
    import pong_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clear,
    input  logic [PERIOD_W-1:0] period,
    output logic                step
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_nxt;
    logic                step_nxt;

    always_comb begin
        cnt_nxt  = '0;
        step_nxt = 1'b0;
        if (en && !clear) begin
            cnt_nxt  = (cnt_q == period - PERIOD_W'(1)) ? '0 : cnt_q + PERIOD_W'(1);
            step_nxt = (cnt_nxt == period - PERIOD_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            step  <= 1'b0;
        end else begin
            cnt_q <= cnt_nxt;
            step  <= step_nxt;
        end
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match controller: serve/rally/point sequencing, scoring and ball speed.
// Build option PONG_SPEEDUP_EN: shorten the step period on every successful return.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter logic [PERIOD_W-1:0] STEP_INIT  = 24'd8_000_000,
    parameter logic [PERIOD_W-1:0] STEP_MIN   = 24'd2_000_000,
    parameter logic [PERIOD_W-1:0] STEP_DEC   = 24'd500_000,
    parameter logic [SHOW_W-1:0]   SHOW_TICKS = 28'd50_000_000,
    parameter score_t              WIN_SCORE  = 4'd7
) (
    input  logic              clk,
    input  logic              rst,
    pong_match_ctrl_if.master bus
);

    state_t              state_q,    state_nxt;
    logic                dir_q,      dir_nxt;
    score_t              score_l_q,  score_l_nxt;
    score_t              score_r_q,  score_r_nxt;
    logic [PERIOD_W-1:0] period_q,   period_nxt;
    logic [SHOW_W-1:0]   show_cnt_q, show_cnt_nxt;
    logic                show_q,     show_nxt;
    logic                over_q,     over_nxt;
    logic                winner_q,   winner_nxt;
    logic                scorer_q,   scorer_nxt;
    logic                load_l_q,   load_l_nxt;
    logic                load_r_q,   load_r_nxt;
    logic                armed_q;

    logic                tick_en_c;
    logic                tick_clear_c;
    logic                win_c;
    logic [PERIOD_W-1:0] ret_period_c;

`ifdef PONG_SPEEDUP_EN
    assign ret_period_c = (period_q > STEP_MIN + STEP_DEC) ? period_q - STEP_DEC : STEP_MIN;
`else
    // Fixed-speed build: the speed-up parameters stay in the port list but feed nothing.
    logic unused_c;
    assign unused_c     = ^{STEP_MIN, STEP_DEC};
    assign ret_period_c = period_q;
`endif

    assign tick_en_c = (state_q == RALLY);
    assign win_c     = scorer_q ? (score_r_q == WIN_SCORE) : (score_l_q == WIN_SCORE);

    always_comb begin
        state_nxt    = state_q;
        dir_nxt      = dir_q;
        score_l_nxt  = score_l_q;
        score_r_nxt  = score_r_q;
        period_nxt   = period_q;
        show_cnt_nxt = show_cnt_q;
        show_nxt     = show_q;
        over_nxt     = over_q;
        winner_nxt   = winner_q;
        scorer_nxt   = scorer_q;
        load_l_nxt   = 1'b0;
        load_r_nxt   = 1'b0;
        tick_clear_c = 1'b0;

        case (state_q)
            SERVE_L: begin
                if (bus.hit_l) begin
                    state_nxt    = RALLY;
                    period_nxt   = STEP_INIT;
                    tick_clear_c = 1'b1;
                end
            end
            SERVE_R: begin
                if (bus.hit_r) begin
                    state_nxt    = RALLY;
                    period_nxt   = STEP_INIT;
                    tick_clear_c = 1'b1;
                end
            end
            RALLY: begin
                // Only the defending side's button matters; an early/late press or an empty bar loses the point.
                if (!dir_q) begin
                    if (bus.hit_r && bus.led == LED_RIGHT_END) begin
                        dir_nxt      = 1'b1;
                        period_nxt   = ret_period_c;
                        tick_clear_c = 1'b1;
                    end else if (bus.hit_r || bus.led == LED_EMPTY) begin
                        state_nxt    = POINT;
                        score_l_nxt  = score_l_q + SCORE_W'(1);
                        scorer_nxt   = 1'b0;
                        show_nxt     = 1'b1;
                        show_cnt_nxt = '0;
                    end
                end else begin
                    if (bus.hit_l && bus.led == LED_LEFT_END) begin
                        dir_nxt      = 1'b0;
                        period_nxt   = ret_period_c;
                        tick_clear_c = 1'b1;
                    end else if (bus.hit_l || bus.led == LED_EMPTY) begin
                        state_nxt    = POINT;
                        score_r_nxt  = score_r_q + SCORE_W'(1);
                        scorer_nxt   = 1'b1;
                        show_nxt     = 1'b1;
                        show_cnt_nxt = '0;
                    end
                end
            end
            POINT: begin
                if (show_cnt_q == SHOW_TICKS - SHOW_W'(1)) begin
                    if (win_c) begin
                        state_nxt  = GAME_OVER;
                        over_nxt   = 1'b1;
                        winner_nxt = scorer_q;
                    end else begin
                        state_nxt = scorer_q ? SERVE_R : SERVE_L;
                        show_nxt  = 1'b0;
                    end
                end else begin
                    show_cnt_nxt = show_cnt_q + SHOW_W'(1);
                end
            end
            GAME_OVER: begin
                if (bus.hit_l || bus.hit_r) begin
                    state_nxt   = SERVE_L;
                    score_l_nxt = '0;
                    score_r_nxt = '0;
                    over_nxt    = 1'b0;
                    show_nxt    = 1'b0;
                end
            end
            default: state_nxt = SERVE_L;
        endcase

        // Serve entry (and the first cycle out of reset) loads the ball and aims it at the opponent.
        if (state_nxt == SERVE_L && (state_q != SERVE_L || !armed_q)) begin
            load_l_nxt = 1'b1;
            dir_nxt    = 1'b0;
        end
        if (state_nxt == SERVE_R && state_q != SERVE_R) begin
            load_r_nxt = 1'b1;
            dir_nxt    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SERVE_L;
            dir_q      <= 1'b0;
            score_l_q  <= '0;
            score_r_q  <= '0;
            period_q   <= STEP_INIT;
            show_cnt_q <= '0;
            show_q     <= 1'b0;
            over_q     <= 1'b0;
            winner_q   <= 1'b0;
            scorer_q   <= 1'b0;
            load_l_q   <= 1'b0;
            load_r_q   <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            dir_q      <= dir_nxt;
            score_l_q  <= score_l_nxt;
            score_r_q  <= score_r_nxt;
            period_q   <= period_nxt;
            show_cnt_q <= show_cnt_nxt;
            show_q     <= show_nxt;
            over_q     <= over_nxt;
            winner_q   <= winner_nxt;
            scorer_q   <= scorer_nxt;
            load_l_q   <= load_l_nxt;
            load_r_q   <= load_r_nxt;
            armed_q    <= 1'b1;
        end
    end

    pong_tick_gen u_tick (
        .clk    (clk),
        .rst    (rst),
        .en     (tick_en_c),
        .clear  (tick_clear_c),
        .period (period_q),
        .step   (bus.step)
    );

    assign bus.load_l     = load_l_q;
    assign bus.load_r     = load_r_q;
    assign bus.dir        = dir_q;
    assign bus.score_l    = score_l_q;
    assign bus.score_r    = score_r_q;
    assign bus.show_score = show_q;
    assign bus.game_over  = over_q;
    assign bus.winner     = winner_q;

endmodule
